// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one RAM port, with read-after-write
// hazard blocking and a tag pipeline that routes read data back to its requester.
module ram_port_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_din0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_din1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_en,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_din,
  input  logic [DATA_WIDTH-1:0] i_dout
);

  // Handshake: i_reqk with its we/addr/din is an offer held until o_gntk; a transfer is
  // i_reqk & o_gntk in the same cycle. o_rvalidk is a one-cycle pulse with no back-pressure.

  localparam int PW = (WRITE_LATENCY > 0) ? WRITE_LATENCY : 1;

  logic                    ptr_q, ptr_d;
  logic [PW-1:0]           pend_v_q;
  logic [ADDR_WIDTH-1:0]   pend_a_q [PW];
  logic [READ_LATENCY-1:0] tag_v_q;
  logic [READ_LATENCY-1:0] tag_id_q;
  logic                    en_q, we_q, id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic                    rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;

  logic                    haz0, haz1, elig0, elig1, gnt0, gnt1, any_gnt;
  logic                    sel_we, rd_issue, ret0, ret1;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_din;

  always_comb begin
    haz0 = 1'b0;
    haz1 = 1'b0;
    for (int i = 0; i < PW; i++) begin
      if (pend_v_q[i] && (pend_a_q[i] == i_addr0)) haz0 = 1'b1;
      if (pend_v_q[i] && (pend_a_q[i] == i_addr1)) haz1 = 1'b1;
    end
  end

  // Only reads are blocked by a pending write; writes are always eligible.
  assign elig0    = i_req0 & (i_we0 | ~haz0);
  assign elig1    = i_req1 & (i_we1 | ~haz1);
  assign gnt0     = i_rst_n & elig0 & (~elig1 | ~ptr_q);
  assign gnt1     = i_rst_n & elig1 & (~elig0 | ptr_q);
  assign any_gnt  = gnt0 | gnt1;
  assign ptr_d    = any_gnt ? gnt0 : ptr_q;
  assign sel_we   = gnt1 ? i_we1   : i_we0;
  assign sel_addr = gnt1 ? i_addr1 : i_addr0;
  assign sel_din  = gnt1 ? i_din1  : i_din0;
  assign rd_issue = en_q & ~we_q;
  assign ret0     = tag_v_q[READ_LATENCY-1] & ~tag_id_q[READ_LATENCY-1];
  assign ret1     = tag_v_q[READ_LATENCY-1] &  tag_id_q[READ_LATENCY-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q     <= 1'b0;
      pend_v_q  <= '0;
      for (int i = 0; i < PW; i++) pend_a_q[i] <= '0;
      tag_v_q   <= '0;
      tag_id_q  <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      id_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      en_q  <= any_gnt;
      we_q  <= any_gnt & sel_we;
      if (any_gnt) begin
        addr_q <= sel_addr;
        din_q  <= sel_din;
        id_q   <= gnt1;
      end
      // Pending-write window covers the WRITE_LATENCY cycles after the grant.
      pend_v_q[0] <= (WRITE_LATENCY > 0) & any_gnt & sel_we;
      pend_a_q[0] <= sel_addr;
      for (int i = 1; i < PW; i++) begin
        pend_v_q[i] <= pend_v_q[i-1];
        pend_a_q[i] <= pend_a_q[i-1];
      end
      tag_v_q[0]  <= rd_issue;
      tag_id_q[0] <= id_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      rvalid0_q <= ret0;
      rvalid1_q <= ret1;
      if (ret0) rdata0_q <= i_dout;
      if (ret1) rdata1_q <= i_dout;
    end
  end

  assign o_gnt0    = gnt0;
  assign o_gnt1    = gnt1;
  assign o_en      = en_q;
  assign o_we      = we_q;
  assign o_addr    = addr_q;
  assign o_din     = din_q;
  assign o_rvalid0 = rvalid0_q;
  assign o_rvalid1 = rvalid1_q;
  assign o_rdata0  = rdata0_q;
  assign o_rdata1  = rdata1_q;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, word width; ADDR_WIDTH, default 6, address width; READ_LATENCY, default 2, range 1..8, RAM cycles from o_en to i_dout valid; WRITE_LATENCY, default 1, range 0..8, RAM cycles from o_en until written data is readable.
REQ-002 One clock; reset is asynchronous and active-low. Ports: i_clk in 1, sole clock, all logic on rising edge; i_rst_n in 1, asynchronous active-low reset.
REQ-003 Requester ports, k = 0 and 1: i_reqk in 1, request; i_wek in 1, 1 = write, 0 = read; i_addrk in ADDR_WIDTH; i_dink in DATA_WIDTH; o_gntk out 1, request accepted this cycle; o_rvalidk out 1, read data valid; o_rdatak out DATA_WIDTH, read data.
REQ-004 RAM-side ports: o_en out 1; o_we out 1; o_addr out ADDR_WIDTH; o_din out DATA_WIDTH; i_dout in DATA_WIDTH. These connect to one port of the team's dual_port_ram.

Function
REQ-005 The block SHALL accept at most one request per cycle; a transfer occurs in cycle N when i_reqk=1 and o_gntk=1.
REQ-006 o_gnt0/o_gnt1 SHALL be combinational from requests, eligibility (REQ-010) and the priority pointer; o_gntk is never 1 while i_reqk=0.
REQ-007 Round-robin: if both requesters are eligible, the requester selected by pointer ptr wins; if only one is eligible, it wins regardless of ptr.
REQ-008 After each grant, ptr SHALL point to the requester not granted. With no grant, ptr is unchanged.
REQ-009 Requesters hold i_wek/i_addrk/i_dink stable while i_reqk=1 and o_gntk=0. The block is not required to check this.
REQ-010 Hazard rule: a write granted in cycle N to address A is pending in cycles N+1 .. N+WRITE_LATENCY. A read to A is ineligible while any pending write targets A; other requests remain eligible. With WRITE_LATENCY=0 there are no pending writes.
REQ-011 Command registration: a grant in cycle N SHALL drive o_en=1 with the granted o_we, o_addr and o_din in cycle N+1. In cycles after no grant, o_en=0 and o_we=0; o_addr/o_din hold their last values.
REQ-012 Read return: for a read granted in cycle N, the block SHALL sample i_dout in cycle N+1+READ_LATENCY. It presents the data on o_rdatak with o_rvalidk=1 for exactly cycle N+2+READ_LATENCY, for the originating requester k only.
REQ-013 Read routing SHALL use a READ_LATENCY-deep tag pipeline of (valid, requester id). Back-to-back reads every cycle SHALL return in order with no loss or stall.
REQ-014 o_rdatak SHALL hold its last value when o_rvalidk=0.
REQ-015 Writes produce no response beyond o_gntk.
REQ-016 A read and a write from different requesters to the same address in the same cycle are sequenced by round-robin alone. If the write is granted, the read becomes hazard-blocked per REQ-010.

Reset
REQ-017 While i_rst_n=0, the following SHALL be 0 asynchronously: ptr, o_en, o_we, o_addr, o_din, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1, the tag pipeline and the pending-write tracker. o_gnt0/o_gnt1 SHALL be 0 during reset.
REQ-018 Reads in flight at reset assertion SHALL be discarded: no o_rvalid pulse after reset release for pre-reset requests.
REQ-019 The first grant after reset release SHALL be the first rising edge with a request present. Requester 0 wins a tie.

Verification
REQ-020 The bench SHALL run with default parameters unless stated, using a dual_port_ram model with matching latencies. Scenarios:
- Single read: reset, req0 read addr 0x05 holding 0xA5 -> gnt0 in cycle N, o_en=1 o_we=0 o_addr=0x05 in N+1, o_rvalid0=1 o_rdata0=0xA5 in N+4, o_rvalid1 stays 0.
- Contention: req0 and req1 both held high for 6 cycles -> grants alternate 0,1,0,1,0,1; each requester gets exactly 3 grants.
- Hazard: req0 write 0x3C to addr 0x10 granted in cycle N; req1 read addr 0x10 asserted in N -> gnt1 low in N+1, granted in N+2, o_rdata1=0x3C. Repeat with WRITE_LATENCY=0 -> read granted in N+1.
- Non-conflicting address: same as the hazard scenario but the read targets 0x11 -> read granted in N+1, no stall.
- Pipelined reads: req1 reads addr 0..7 on 8 consecutive cycles with READ_LATENCY=4 -> 8 consecutive o_rvalid1 pulses, data in address order.
- Reset mid-read: read granted, i_rst_n low at N+2 and released at N+4 -> all outputs 0 during reset, no o_rvalid pulse afterwards, next request granted normally.
